// File: rtl/mway_stage.sv
// mway_stage: one level of a pipelined multi-way search tree.
// Reads a node of sorted keys, picks a branch and extends the address.
module mway_stage #(
    parameter int A_WIDTH   = 8,
    parameter int D_WIDTH   = 16,
    parameter int BR_BITS   = 2,
    parameter int STAGE_NUM = 1,
    parameter int OPT_LEVEL = 0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  wr_en_i,
    input  logic [A_WIDTH-1:0]                    wr_addr_i,
    input  logic [(2**BR_BITS-1)*D_WIDTH-1:0]     wr_data_i,
    input  logic                                  lookup_en_i,
    input  logic [A_WIDTH-1:0]                    lookup_addr_i,
    input  logic [D_WIDTH-1:0]                    lookup_data_i,
    input  logic                                  lookup_hit_i,
    output logic                                  lookup_en_o,
    output logic [A_WIDTH-1:0]                    lookup_addr_o,
    output logic [D_WIDTH-1:0]                    lookup_data_o,
    output logic                                  lookup_hit_o
);

    localparam int K     = 2**BR_BITS - 1;
    localparam int KW    = K * D_WIDTH;
    localparam int SA_W  = (STAGE_NUM == 0) ? 1 : BR_BITS * STAGE_NUM;
    localparam int NODES = 2**SA_W;

    logic [KW-1:0]      r_mem [NODES];

    logic               r1_en, r1_hit, r1_byp;
    logic [SA_W-1:0]    r1_node;
    logic [D_WIDTH-1:0] r1_data;
    logic [KW-1:0]      r1_wdata;

    logic               r2_en, r2_hit, r2_byp;
    logic [SA_W-1:0]    r2_node;
    logic [D_WIDTH-1:0] r2_data;
    logic [KW-1:0]      r2_wdata;
    logic [KW-1:0]      r2_rd;

    logic [KW-1:0]      w_keys;
    logic [BR_BITS-1:0] w_idx;
    logic               w_eq;
    logic [A_WIDTH-1:0] w_addr;
    logic               w_hit;

    logic               w_o_en, w_o_hit;
    logic [A_WIDTH-1:0] w_o_addr;
    logic [D_WIDTH-1:0] w_o_data;

    logic               r_o_en, r_o_hit;
    logic [A_WIDTH-1:0] r_o_addr;
    logic [D_WIDTH-1:0] r_o_data;

    logic               w_unused;
    assign w_unused = ^{wr_addr_i, lookup_addr_i, r2_node};

    // Node RAM write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) r_mem[wr_addr_i[SA_W-1:0]] <= wr_data_i;
    end

    // Capture lookup and decide same-cycle write bypass.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r1_en    <= 1'b0;
            r1_hit   <= 1'b0;
            r1_byp   <= 1'b0;
            r1_node  <= '0;
            r1_data  <= '0;
            r1_wdata <= '0;
        end else begin
            r1_en    <= lookup_en_i;
            r1_hit   <= lookup_hit_i;
            r1_byp   <= wr_en_i &&
                        (wr_addr_i[SA_W-1:0] == lookup_addr_i[SA_W-1:0]);
            r1_node  <= lookup_addr_i[SA_W-1:0];
            r1_data  <= lookup_data_i;
            r1_wdata <= wr_data_i;
        end
    end

    // Synchronous RAM read of the captured node.
    always_ff @(posedge clk_i) begin
        r2_rd <= r_mem[r1_node];
    end

    // Pipeline registers travelling alongside the RAM read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r2_en    <= 1'b0;
            r2_hit   <= 1'b0;
            r2_byp   <= 1'b0;
            r2_node  <= '0;
            r2_data  <= '0;
            r2_wdata <= '0;
        end else begin
            r2_en    <= r1_en;
            r2_hit   <= r1_hit;
            r2_byp   <= r1_byp;
            r2_node  <= r1_node;
            r2_data  <= r1_data;
            r2_wdata <= r1_wdata;
        end
    end

    // Priority compare: lowest key not below the search value wins.
    always_comb begin
        w_keys = r2_byp ? r2_wdata : r2_rd;
        w_idx  = '1;
        w_eq   = 1'b0;
        for (int j = K - 1; j >= 0; j--) begin
            if (r2_data <= w_keys[j*D_WIDTH +: D_WIDTH]) begin
                w_idx = BR_BITS'(j);
                w_eq  = (r2_data == w_keys[j*D_WIDTH +: D_WIDTH]);
            end
        end
    end

    if (STAGE_NUM == 0) begin : g_root
        assign w_addr = A_WIDTH'(w_idx);
    end else begin : g_inner
        assign w_addr = A_WIDTH'({r2_node, w_idx});
    end

    assign w_hit = r2_en & (r2_hit | w_eq);

    if (OPT_LEVEL == 1) begin : g_opt
        logic               r3_en, r3_hit;
        logic [A_WIDTH-1:0] r3_addr;
        logic [D_WIDTH-1:0] r3_data;

        // Extra register after the compare for timing.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r3_en   <= 1'b0;
                r3_hit  <= 1'b0;
                r3_addr <= '0;
                r3_data <= '0;
            end else begin
                r3_en   <= r2_en;
                r3_hit  <= w_hit;
                r3_addr <= w_addr;
                r3_data <= r2_data;
            end
        end

        assign w_o_en   = r3_en;
        assign w_o_hit  = r3_hit;
        assign w_o_addr = r3_addr;
        assign w_o_data = r3_data;
    end else begin : g_comb
        assign w_o_en   = r2_en;
        assign w_o_hit  = w_hit;
        assign w_o_addr = w_addr;
        assign w_o_data = r2_data;
    end

    // Output register feeding the next stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_o_en   <= 1'b0;
            r_o_hit  <= 1'b0;
            r_o_addr <= '0;
            r_o_data <= '0;
        end else begin
            r_o_en   <= w_o_en;
            r_o_hit  <= w_o_hit;
            r_o_addr <= w_o_addr;
            r_o_data <= w_o_data;
        end
    end

    assign lookup_en_o   = r_o_en;
    assign lookup_hit_o  = r_o_hit;
    assign lookup_addr_o = r_o_addr;
    assign lookup_data_o = r_o_data;

endmodule

// File: tb/tb_mway_stage.sv
// tb_mway_stage: scoreboard bench for mway_stage.
// Three instances: 4-way latency 2, 4-way latency 3, 8-way root.
module tb_mway_stage;

    typedef struct {
        int         due;
        int         tag;
        logic [7:0] addr;
        logic [15:0] data;
        logic       hit;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tag   = 0;

    logic        rst = 1'b1;
    logic        we = 1'b0, le = 1'b0, lh = 1'b0;
    logic [7:0]  wa = '0, la = '0;
    logic [47:0] wd = '0;
    logic [15:0] ld = '0;

    logic         we2 = 1'b0, le2 = 1'b0, lh2 = 1'b0;
    logic [7:0]   wa2 = '0, la2 = '0;
    logic [111:0] wd2 = '0;
    logic [15:0]  ld2 = '0;

    logic        o0_en, o0_hit, o1_en, o1_hit, o2_en, o2_hit;
    logic [7:0]  o0_addr, o1_addr, o2_addr;
    logic [15:0] o0_data, o1_data, o2_data;

    logic [47:0] m0 [4];

    ent_t q0[$];
    ent_t q1[$];
    ent_t q2[$];
    ent_t me;

    mway_stage #(.A_WIDTH(8), .D_WIDTH(16), .BR_BITS(2),
                 .STAGE_NUM(1), .OPT_LEVEL(0)) u0 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(we), .wr_addr_i(wa),
        .wr_data_i(wd), .lookup_en_i(le), .lookup_addr_i(la),
        .lookup_data_i(ld), .lookup_hit_i(lh), .lookup_en_o(o0_en),
        .lookup_addr_o(o0_addr), .lookup_data_o(o0_data),
        .lookup_hit_o(o0_hit));

    mway_stage #(.A_WIDTH(8), .D_WIDTH(16), .BR_BITS(2),
                 .STAGE_NUM(1), .OPT_LEVEL(1)) u1 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(we), .wr_addr_i(wa),
        .wr_data_i(wd), .lookup_en_i(le), .lookup_addr_i(la),
        .lookup_data_i(ld), .lookup_hit_i(lh), .lookup_en_o(o1_en),
        .lookup_addr_o(o1_addr), .lookup_data_o(o1_data),
        .lookup_hit_o(o1_hit));

    mway_stage #(.A_WIDTH(8), .D_WIDTH(16), .BR_BITS(3),
                 .STAGE_NUM(0), .OPT_LEVEL(0)) u2 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(we2), .wr_addr_i(wa2),
        .wr_data_i(wd2), .lookup_en_i(le2), .lookup_addr_i(la2),
        .lookup_data_i(ld2), .lookup_hit_i(lh2), .lookup_en_o(o2_en),
        .lookup_addr_o(o2_addr), .lookup_data_o(o2_data),
        .lookup_hit_o(o2_hit));

    // Scoreboard: pop entries whose latency expired, else expect idle.
    always @(posedge clk) begin
        cyc++;
        #1;
        total++;
        if (q0.size() != 0 && q0[0].due == cyc) begin
            me = q0.pop_front();
            if (o0_en !== 1'b1 || o0_addr !== me.addr ||
                o0_data !== me.data || o0_hit !== me.hit) begin
                bad++;
                $display("FAIL u0_lookup tag=%0d got en=%b addr=%b data=%0d hit=%b want en=1 addr=%b data=%0d hit=%b",
                         me.tag, o0_en, o0_addr, o0_data, o0_hit,
                         me.addr, me.data, me.hit);
            end
        end else if (o0_en !== 1'b0 || o0_hit !== 1'b0) begin
            bad++;
            $display("FAIL u0_idle cyc=%0d got en=%b hit=%b want en=0 hit=0",
                     cyc, o0_en, o0_hit);
        end
        total++;
        if (q1.size() != 0 && q1[0].due == cyc) begin
            me = q1.pop_front();
            if (o1_en !== 1'b1 || o1_addr !== me.addr ||
                o1_data !== me.data || o1_hit !== me.hit) begin
                bad++;
                $display("FAIL u1_lookup tag=%0d got en=%b addr=%b data=%0d hit=%b want en=1 addr=%b data=%0d hit=%b",
                         me.tag, o1_en, o1_addr, o1_data, o1_hit,
                         me.addr, me.data, me.hit);
            end
        end else if (o1_en !== 1'b0 || o1_hit !== 1'b0) begin
            bad++;
            $display("FAIL u1_idle cyc=%0d got en=%b hit=%b want en=0 hit=0",
                     cyc, o1_en, o1_hit);
        end
        total++;
        if (q2.size() != 0 && q2[0].due == cyc) begin
            me = q2.pop_front();
            if (o2_en !== 1'b1 || o2_addr !== me.addr ||
                o2_data !== me.data || o2_hit !== me.hit) begin
                bad++;
                $display("FAIL u2_lookup tag=%0d got en=%b addr=%b data=%0d hit=%b want en=1 addr=%b data=%0d hit=%b",
                         me.tag, o2_en, o2_addr, o2_data, o2_hit,
                         me.addr, me.data, me.hit);
            end
        end else if (o2_en !== 1'b0 || o2_hit !== 1'b0) begin
            bad++;
            $display("FAIL u2_idle cyc=%0d got en=%b hit=%b want en=0 hit=0",
                     cyc, o2_en, o2_hit);
        end
    end

    function automatic logic [8:0] mdl(input logic [47:0] keys,
                                       input logic [1:0] node,
                                       input logic [15:0] d,
                                       input logic h);
        logic [1:0] idx;
        logic eq;
        logic found;
        idx = 2'd3;
        eq = 1'b0;
        found = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (!found && d <= keys[j*16 +: 16]) begin
                found = 1'b1;
                idx = j[1:0];
                eq = (d == keys[j*16 +: 16]);
            end
        end
        return {h | eq, 4'b0000, node, idx};
    endfunction

    // One cycle of stimulus for the two 4-way instances.
    task automatic cyc01(input logic r, input logic w_en,
                         input logic [7:0] w_a, input logic [47:0] w_d,
                         input logic l_en, input logic [7:0] l_a,
                         input logic [15:0] l_d, input logic l_h,
                         input logic [7:0] e_addr, input logic e_hit);
        ent_t e;
        @(negedge clk);
        rst = r;
        we = w_en; wa = w_a; wd = w_d;
        le = l_en; la = l_a; ld = l_d; lh = l_h;
        if (w_en) m0[w_a[1:0]] = w_d;
        if (r) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else if (l_en) begin
            tag++;
            e.tag = tag; e.addr = e_addr; e.data = l_d; e.hit = e_hit;
            e.due = cyc + 1 + 2;
            q0.push_back(e);
            e.due = cyc + 1 + 3;
            q1.push_back(e);
        end
    endtask

    // One cycle of stimulus for the 8-way root instance.
    task automatic cyc2(input logic w_en, input logic [7:0] w_a,
                        input logic [111:0] w_d, input logic l_en,
                        input logic [7:0] l_a, input logic [15:0] l_d,
                        input logic l_h, input logic [7:0] e_addr,
                        input logic e_hit);
        ent_t e;
        @(negedge clk);
        we2 = w_en; wa2 = w_a; wd2 = w_d;
        le2 = l_en; la2 = l_a; ld2 = l_d; lh2 = l_h;
        if (l_en) begin
            tag++;
            e.tag = tag; e.addr = e_addr; e.data = l_d; e.hit = e_hit;
            e.due = cyc + 1 + 2;
            q2.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b0;
            we = 1'b0; le = 1'b0; lh = 1'b0;
            we2 = 1'b0; le2 = 1'b0; lh2 = 1'b0;
        end
    endtask

    task automatic test_reset();
        cyc01(1, 0, 0, 0, 1, 8'd2, 16'd5, 1, 0, 0);
        cyc01(1, 0, 0, 0, 1, 8'd2, 16'd5, 1, 0, 0);
        @(negedge clk);
        total++;
        if ({o0_en, o0_hit, o0_addr, o0_data} !== 26'd0) begin
            bad++;
            $display("FAIL reset_u0 got en=%b hit=%b addr=%h data=%h want all 0",
                     o0_en, o0_hit, o0_addr, o0_data);
        end
        total++;
        if ({o1_en, o1_hit, o1_addr, o1_data} !== 26'd0) begin
            bad++;
            $display("FAIL reset_u1 got en=%b hit=%b addr=%h data=%h want all 0",
                     o1_en, o1_hit, o1_addr, o1_data);
        end
        total++;
        if ({o2_en, o2_hit, o2_addr, o2_data} !== 26'd0) begin
            bad++;
            $display("FAIL reset_u2 got en=%b hit=%b addr=%h data=%h want all 0",
                     o2_en, o2_hit, o2_addr, o2_data);
        end
        idle(1);
    endtask

    task automatic test_keys();
        cyc01(0, 1, 8'd0, {16'd300, 16'd200, 16'd100}, 0, 0, 0, 0, 0, 0);
        cyc01(0, 1, 8'd1, {16'd3, 16'd2, 16'd1}, 0, 0, 0, 0, 0, 0);
        cyc01(0, 1, 8'd3, {16'd9, 16'd8, 16'd7}, 0, 0, 0, 0, 0, 0);
        cyc01(0, 1, 8'd2, {16'd30, 16'd20, 16'd10}, 0, 0, 0, 0, 0, 0);
        cyc01(0, 0, 0, 0, 1, 8'd2, 16'd5,  0, 8'b1000, 0);
        cyc01(0, 0, 0, 0, 1, 8'd2, 16'd20, 0, 8'b1001, 1);
        cyc01(0, 0, 0, 0, 1, 8'd2, 16'd25, 0, 8'b1010, 0);
        cyc01(0, 0, 0, 0, 1, 8'd2, 16'd31, 0, 8'b1011, 0);
        idle(5);
    endtask

    task automatic test_bypass();
        cyc01(0, 1, 8'd1, {16'd3, 16'd2, 16'd1}, 0, 0, 0, 0, 0, 0);
        cyc01(0, 1, 8'd1, {16'd300, 16'd200, 16'd100},
              1, 8'd1, 16'd150, 0, 8'b0101, 0);
        cyc01(0, 1, 8'd1, {16'd3, 16'd2, 16'd1}, 0, 0, 0, 0, 0, 0);
        cyc01(0, 0, 0, 0, 1, 8'd1, 16'd150, 0, 8'b0111, 0);
        cyc01(0, 1, 8'd1, {16'd300, 16'd200, 16'd100},
              1, 8'd1, 16'd200, 0, 8'b0101, 1);
        cyc01(0, 1, 8'd0, {16'd3, 16'd2, 16'd1},
              1, 8'd1, 16'd100, 0, 8'b0100, 1);
        idle(5);
    endtask

    task automatic test_hit_prop();
        cyc01(0, 0, 0, 0, 1, 8'd2, 16'd25, 1, 8'b1010, 1);
        cyc01(0, 0, 0, 0, 0, 8'd2, 16'd20, 1, 0, 0);
        cyc01(0, 0, 0, 0, 0, 8'd2, 16'd20, 1, 0, 0);
        cyc01(0, 0, 0, 0, 1, 8'd2, 16'd99, 1, 8'b1011, 1);
        cyc01(0, 0, 0, 0, 0, 8'd2, 16'd99, 1, 0, 0);
        idle(5);
    endtask

    task automatic test_reset_midflight();
        cyc01(0, 0, 0, 0, 1, 8'd2, 16'd5,  0, 8'b1000, 0);
        cyc01(0, 0, 0, 0, 1, 8'd2, 16'd20, 0, 8'b1001, 1);
        cyc01(1, 1, 8'd3, {16'd300, 16'd200, 16'd100},
              1, 8'd2, 16'd10, 0, 0, 0);
        cyc01(0, 0, 0, 0, 1, 8'd2, 16'd25, 0, 8'b1010, 0);
        idle(5);
        cyc01(0, 0, 0, 0, 1, 8'd3, 16'd250, 0, 8'b1110, 0);
        cyc01(0, 0, 0, 0, 1, 8'd3, 16'd200, 0, 8'b1101, 1);
        idle(5);
    endtask

    task automatic test_wide();
        logic [111:0] k0, k1;
        for (int j = 0; j < 7; j++) begin
            k0[j*16 +: 16] = 16'(10 * (j + 1));
            k1[j*16 +: 16] = 16'(100 * (j + 1));
        end
        cyc2(1, 8'd0, k0, 0, 0, 0, 0, 0, 0);
        cyc2(1, 8'd1, k1, 0, 0, 0, 0, 0, 0);
        cyc2(0, 0, 0, 1, 8'd0, 16'd70, 0, 8'b110, 1);
        cyc2(0, 0, 0, 1, 8'd0, 16'd71, 0, 8'b111, 0);
        cyc2(0, 0, 0, 1, 8'd0, 16'd0,  0, 8'b000, 0);
        cyc2(0, 0, 0, 1, 8'd0, 16'd10, 1, 8'b000, 1);
        cyc2(0, 0, 0, 1, 8'hF1, 16'd250, 0, 8'b010, 0);
        cyc2(0, 0, 0, 1, 8'h02, 16'd65535, 0, 8'b111, 0);
        cyc2(0, 0, 0, 1, 8'h03, 16'd700, 0, 8'b110, 1);
        idle(5);
    endtask

    task automatic test_back_to_back();
        logic        w_en, l_en, l_h;
        logic [7:0]  w_a, l_a;
        logic [47:0] kd, keys;
        logic [15:0] l_d;
        logic [8:0]  ex;
        for (int i = 0; i < 60; i++) begin
            w_en = ($urandom_range(0, 1) == 1);
            w_a = 8'($urandom_range(0, 255));
            for (int j = 0; j < 3; j++)
                kd[j*16 +: 16] = 16'($urandom_range(0, 40));
            l_en = ($urandom_range(0, 3) != 0);
            l_a = 8'($urandom_range(0, 255));
            l_d = 16'($urandom_range(0, 45));
            l_h = ($urandom_range(0, 3) == 0);
            keys = (w_en && w_a[1:0] == l_a[1:0]) ? kd : m0[l_a[1:0]];
            ex = mdl(keys, l_a[1:0], l_d, l_h);
            cyc01(0, w_en, w_a, kd, l_en, l_a, l_d, l_h, ex[7:0], ex[8]);
        end
        idle(6);
    endtask

    initial begin
        test_reset();
        test_keys();
        test_bypass();
        test_hit_prop();
        test_reset_midflight();
        test_wide();
        test_back_to_back();
        idle(4);
        total++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want 0",
                     q0.size() + q1.size() + q2.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mway_stage.md
# mway_stage

Pipelined lookup stage for a multi-way search tree, generalising the fixed 3-key/4-way stage. Each node holds K = 2^BR_BITS − 1 keys in a stage-local RAM. Per lookup, the stage reads the node addressed by the incoming address and picks one of 2^BR_BITS branches. It appends the branch index to the address and carries a sticky exact-match flag. Stages are chained: stage N's outputs feed stage N+1's lookup inputs, and a control path writes node contents.

## Interface
- A_WIDTH, 8: lookup address width. Must be ≥ SA_W + BR_BITS.
- D_WIDTH, 16: key/data width, unsigned.
- BR_BITS, 2: branch bits per stage. Fanout is 2^BR_BITS; K = 2^BR_BITS − 1 keys per node.
- STAGE_NUM, 1: tree level. Node address width SA_W = 1 if STAGE_NUM==0, else BR_BITS*STAGE_NUM.
- OPT_LEVEL, 0: 0 = combinational compare; 1 = extra register after compare (+1 latency).
- clk_i  in  1  clock. One clock only; reset is synchronous and active-high.
- rst_i  in  1  synchronous active-high reset.
- wr_en_i  in  1  node write strobe.
- wr_addr_i  in  A_WIDTH  node address; only bits [SA_W-1:0] are used.
- wr_data_i  in  K*D_WIDTH  keys; key j at [j*D_WIDTH +: D_WIDTH].
- lookup_en_i  in  1  lookup valid.
- lookup_addr_i  in  A_WIDTH  node address from previous stage.
- lookup_data_i  in  D_WIDTH  search value.
- lookup_hit_i  in  1  match flag from previous stage.
- lookup_en_o  out  1  lookup valid to next stage.
- lookup_addr_o  out  A_WIDTH  extended address.
- lookup_data_o  out  D_WIDTH  search value, passed through unchanged.
- lookup_hit_o  out  1  accumulated match flag.

## Operation
- Node RAM: 2^SA_W entries of K*D_WIDTH bits, synchronous read with 1-cycle latency. RAM contents are not reset.
- Branch index `idx` (BR_BITS wide): the lowest j with lookup_data ≤ key[j]; if no key satisfies this, idx = K (all ones). The comparison is priority-encoded on j, so unsorted keys still give a defined result.
- lookup_addr_o = zero-extend({addr[SA_W-1:0], idx}) to A_WIDTH. For STAGE_NUM==0, lookup_addr_o = zero-extend(idx).
- lookup_hit_o = lookup_en_o & (hit_in_delayed | (idx != K & data == key[idx])).
- Write/lookup coherency: a lookup accepted at cycle t sees node contents including every write at cycles ≤ t.
  - If wr_en_i is high at cycle t and wr_addr_i[SA_W-1:0] == lookup_addr_i[SA_W-1:0], the stage uses wr_data_i (registered bypass), not the RAM read.
  - A write at t+1 or later does not affect that lookup.
- Writes and lookups may occur in the same cycle, every cycle. There is no backpressure.
- Pipeline registers en/addr/data/hit load every cycle. The addr/data fields are unqualified when en is 0.

## Timing
- Latency L = 2 + OPT_LEVEL cycles, from lookup_en_i sampled at edge t to lookup_en_o high after edge t+L.
- Throughput: one lookup per cycle. Back-to-back lookups emerge in order, with no bubbles inserted.
- Reset: any edge with rst_i high clears all pipeline registers. lookup_en_o, lookup_addr_o, lookup_data_o and lookup_hit_o are therefore 0 after that edge.
  - Lookups in flight at reset are dropped.
  - A lookup presented in the same cycle as rst_i is discarded.
  - A write presented in the same cycle as rst_i is still performed into the RAM.
- After rst_i falls, the first valid output appears L cycles after the first accepted lookup_en_i.
- Bypass compare uses the address and write data sampled at the same edge. The bypass selection is registered alongside the RAM read.

## Test plan
- Keys, BR_BITS=2, D_WIDTH=16, STAGE_NUM=1, OPT_LEVEL=0: write keys {10,20,30} to node 2, then look up 5, 20, 25, 31 at node 2 on consecutive cycles.
  - Required: lookup_addr_o = 4'b1000, 4'b1001, 4'b1010, 4'b1011 at cycles +2..+5.
  - Required: hits 0, 1, 0, 0; data passed through unchanged.
- Coherency bypass: hold node 1 = {1,2,3}. In one cycle, write {100,200,300} to node 1 and look up 150 at node 1.
  - Required: idx = 1 (bypassed data).
  - Companion case: write in the next cycle instead → idx = 3 (old data).
- Reset mid-flight, OPT_LEVEL=1: issue lookups at cycles 0–3 and assert rst_i at cycle 2.
  - Required: lookup_en_o = 0 for all dropped lookups; latency-3 output for lookups issued after reset.
- Wide fanout: BR_BITS=3, STAGE_NUM=0, keys {10,20,…,70}, lookup 70 with lookup_hit_i=0.
  - Required: lookup_addr_o = 3'b110, hit = 1.
  - Required: lookup 71 → lookup_addr_o = 3'b111, hit = 0.
- Hit propagation: lookup_hit_i=1 with no key match → lookup_hit_o = 1. lookup_en_i=0 with lookup_hit_i=1 → lookup_hit_o = 0.
